// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared defaults and helpers for the fetch queue
// Purpose: default widths, reset PC, NOP encoding and a constant clog2 helper
//          used to size pointers and the occupancy counter.
// Ports: none (package).
package fetch_queue_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int PCLEN_DEF    = 10;
  localparam int DEPTH_DEF    = 4;
  localparam int RESET_PC_DEF = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Smallest r with 2**r >= value; evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory, redirect and decode-side bundle
// Purpose: groups the fetch queue's memory request, redirect and output
//          handshake signals. The slave modport is the fetch queue itself,
//          the master modport is the surrounding memory/decode environment.
// Signals: imem_req/imem_addr/imem_rdata (memory), redirect/redirect_pc,
//          out_valid/out_ready/out_instr/out_pc (decode), count (occupancy).
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PCLEN = PCLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int CW = clog2(DEPTH) + 1;

  logic             imem_req;
  logic [PCLEN-1:0] imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic             redirect;
  logic [PCLEN-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [PCLEN-1:0] out_pc;
  logic [CW-1:0]    count;

  modport slave (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport master (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - synchronous FIFO with flush for fetch entries
// Purpose: DEPTH-entry storage with read/write pointers and occupancy count;
//          flush_i clears pointers and count in one cycle.
// Ports: clk_i, reset_i (sync, active-low), flush_i, push_i/wdata_i,
//        pop_i, rdata_o (head entry), count_o (occupancy).
module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW + 1)'(push_i) - (PW + 1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // The fetch credit check must make a push into a full queue impossible.
  always_ff @(posedge clk_i) begin
    if (reset_i && !flush_i) assert (!(push_i && (count_q == DEPTH_C)));
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential PC fetch front end with decoupling queue
// Purpose: generates sequential fetch PCs, issues reads to a 1-cycle-latency
//          instruction memory and buffers {pc,instr} pairs for decode. A
//          redirect flushes the queue and invalidates the in-flight read by
//          toggling the epoch bit.
// Ports: clk_i, reset_i (sync, active-low), bus (fetch_queue_if.slave:
//        imem_*, redirect*, out_* handshake, count).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int PCLEN    = PCLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input logic          clk_i,
  input logic          reset_i,
  fetch_queue_if.slave bus
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [PCLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PCLEN-1:0]      req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  req_epoch_q, req_epoch_d;
  logic                  epoch_q, epoch_d;
  logic                  valid, pop, push, issue;
  logic [CW:0]           credit;
  logic [CW-1:0]         fifo_count;
  logic [XLEN+PCLEN-1:0] head;

  always_comb begin
    valid  = reset_i && (fifo_count != '0) && !bus.redirect;
    pop    = valid && bus.out_ready;
    // Slots already promised: queued entries plus the read in flight,
    // minus the entry leaving this cycle.
    credit = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    issue  = reset_i && !bus.redirect && (credit < DEPTH_C);
    // A response from an older epoch belongs to a squashed path.
    push   = reset_i && inflight_q && (req_epoch_q == epoch_q) && !bus.redirect;

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    inflight_d  = issue;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + PCLEN'(PC_STEP);
      req_pc_d    = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fetch_pc_q  <= PCLEN'(RESET_PC);
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
    end
  end

  sync_fifo #(
    .WIDTH(XLEN + PCLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .flush_i(bus.redirect),
    .push_i (push),
    .wdata_i({req_pc_q, bus.imem_rdata}),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(fifo_count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = reset_i ? head[XLEN-1:0] : '0;
  assign bus.out_pc    = reset_i ? head[XLEN +: PCLEN] : '0;
  assign bus.count     = fifo_count;

endmodule
